addr_range_monitor: RTL and testbench
=====================================

ADDR_RANGE_MONITOR -- requirements
Module: addr_range_monitor

Interface
REQ-001 The block SHALL have parameter AW, default 8, address width in bits.
REQ-002 The block SHALL have parameter NCH, default 4, number of independently monitored channels.
REQ-003 The block SHALL have parameter CW, default 8, width of each per-channel violation counter.
REQ-004 The block SHALL have parameter THRESH, default 4, violation count at which irq asserts; legal range 1..2^CW-1.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 en  input  1  global monitor enable; 0 freezes all state.
REQ-009 valid  input  NCH  per-channel access strobe.
REQ-010 addr  input  NCH*AW  per-channel address; channel i is addr[i*AW +: AW].
REQ-011 lo, hi  input  NCH*AW each  per-channel inclusive lower and upper bounds.
REQ-012 clr  input  NCH  per-channel clear of err, count and cap_addr.
REQ-013 err  output  NCH  sticky per-channel violation flag.
REQ-014 count  output  NCH*CW  per-channel saturating violation count.
REQ-015 cap_addr  output  NCH*AW  address of the first violation since the last clear or reset.
REQ-016 cfg_err  output  NCH  registered flag, 1 while lo > hi on that channel.
REQ-017 irq  output  1  registered; 1 while any channel count >= THRESH.

Function
REQ-018 A violation on channel i SHALL occur in a cycle where en=1, valid[i]=1, cfg_err condition lo[i]<=hi[i] holds, and addr[i]<lo[i] or addr[i]>hi[i]; bounds are inclusive and comparisons are unsigned.
REQ-019 Each channel SHALL have two states, CLEAN (err=0) and FAULT (err=1): CLEAN->FAULT on violation; FAULT->CLEAN only on clr[i]; FAULT holds on further violations.
REQ-020 err, count and cap_addr SHALL update at the rising edge sampling the violation, visible in the next cycle (latency 1).
REQ-021 count SHALL increment by 1 per violation and saturate at 2^CW-1 without wrapping.
REQ-022 cap_addr SHALL load only on a violation in state CLEAN; later violations SHALL NOT overwrite it.
REQ-023 When clr[i] and a violation coincide on channel i, the result SHALL be err=1, count=1, cap_addr=current addr.
REQ-024 clr[i] without a violation SHALL set err=0, count=0, cap_addr=0 regardless of en.
REQ-025 When lo[i] > hi[i], the channel SHALL register no violations and cfg_err[i] SHALL be 1 one cycle later.
REQ-026 irq SHALL be registered from the post-update counts, asserting one cycle after a count reaches THRESH (latency 2 from the violation), and deasserting one cycle after all counts fall below THRESH.
REQ-027 Channels SHALL be fully independent; simultaneous violations on all channels SHALL all be recorded in the same cycle.
REQ-028 With en=0, valid SHALL be ignored and err, count, cap_addr SHALL hold, except for clr.

Reset
REQ-029 On rst_n=0, err, count, cap_addr, cfg_err and irq SHALL clear to 0 immediately, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight update; the first violation after deassertion SHALL follow REQ-020.

Configuration
REQ-031 With ADDR_RANGE_MON_ASSERT_EN defined, a per-channel concurrent assertion SHALL fire $error "Address is out of range" on every violation, disabled while rst_n=0.
REQ-032 Without ADDR_RANGE_MON_ASSERT_EN, no assertions SHALL be compiled; port behaviour SHALL be identical.

Verification
REQ-033 ch0 lo=0x10 hi=0x20, addr 0x10, 0x20, 0x21 with valid -> only 0x21 violates; err[0]=1, count[0]=1, cap_addr[0]=0x21.
REQ-034 CW=2, ch1 five violations at 0x05, 0x06, 0x07, 0x08, 0x09 with lo=0x40 -> count[1] 1,2,3,3,3; cap_addr[1]=0x05.
REQ-035 THRESH=4, four ch2 violations -> irq=1 two cycles after the fourth; clr[2] -> irq=0 two cycles later.
REQ-036 clr[3] and violation at 0xFF (hi=0x80) in the same cycle with count[3]=7 -> count[3]=1, err[3]=1, cap_addr[3]=0xFF.
REQ-037 ch0 lo=0x30 hi=0x20, addr 0x00 valid -> cfg_err[0]=1, err[0]=0, count[0]=0.
REQ-038 rst_n low between clock edges during violation stream -> all outputs 0 immediately; next violation gives count=1.

Source files
------------

// File: rtl/addr_range_monitor.sv
// rtl/addr_range_monitor.sv - multi-channel address range monitor with sticky error, counters and irq
// Optional feature macro: ADDR_RANGE_MON_ASSERT_EN enables per-channel out-of-range assertions.
module addr_range_monitor #(
  parameter int AW     = 8,
  parameter int NCH    = 4,
  parameter int CW     = 8,
  parameter int THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCH-1:0]    valid,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*AW-1:0] lo,
  input  logic [NCH*AW-1:0] hi,
  input  logic [NCH-1:0]    clr,
  output logic [NCH-1:0]    err,
  output logic [NCH*CW-1:0] count,
  output logic [NCH*AW-1:0] cap_addr,
  output logic [NCH-1:0]    cfg_err,
  output logic              irq
);

  typedef enum logic {
    CLEAN = 1'b0,
    FAULT = 1'b1
  } ch_state_e;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  ch_state_e      state_q [NCH];
  ch_state_e      state_d [NCH];
  logic [CW-1:0]  count_q [NCH];
  logic [CW-1:0]  count_d [NCH];
  logic [AW-1:0]  cap_q   [NCH];
  logic [AW-1:0]  cap_d   [NCH];
  logic [NCH-1:0] cfg_err_q;
  logic [NCH-1:0] cfg_err_d;
  logic           irq_q;
  logic           irq_d;

  logic [NCH-1:0] bad_cfg;
  logic [NCH-1:0] out_of_range;
  logic [NCH-1:0] viol;

  // Per-channel decode: inverted bounds, inclusive unsigned range test, qualified violation.
  always_comb begin
    bad_cfg      = '0;
    out_of_range = '0;
    viol         = '0;
    for (int i = 0; i < NCH; i++) begin
      bad_cfg[i]      = lo[i*AW +: AW] > hi[i*AW +: AW];
      out_of_range[i] = (addr[i*AW +: AW] < lo[i*AW +: AW]) ||
                        (addr[i*AW +: AW] > hi[i*AW +: AW]);
      viol[i]         = en && valid[i] && !bad_cfg[i] && out_of_range[i];
    end
  end

  // Per-channel CLEAN/FAULT next state with saturating count and first-violation capture.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      cap_d[i]   = cap_q[i];
      if (clr[i]) begin
        // A violation coinciding with clear starts a fresh record rather than being lost.
        if (viol[i]) begin
          state_d[i] = FAULT;
          count_d[i] = CNT_ONE;
          cap_d[i]   = addr[i*AW +: AW];
        end else begin
          state_d[i] = CLEAN;
          count_d[i] = '0;
          cap_d[i]   = '0;
        end
      end else if (viol[i]) begin
        state_d[i] = FAULT;
        if (count_q[i] != CNT_MAX) begin
          count_d[i] = count_q[i] + CNT_ONE;
        end
        if (state_q[i] == CLEAN) begin
          cap_d[i] = addr[i*AW +: AW];
        end
      end
    end
  end

  // Config flag tracks the bounds; irq follows the already-updated counts, adding one cycle.
  always_comb begin
    cfg_err_d = bad_cfg;
    irq_d     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (count_q[i] >= THRESH_C) begin
        irq_d = 1'b1;
      end
    end
  end

  // Channel state registers; reset discards any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= CLEAN;
        count_q[i] <= '0;
        cap_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
        cap_q[i]   <= cap_d[i];
      end
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
      irq_q     <= irq_d;
    end
  end

  // Flatten per-channel state onto the packed output buses.
  always_comb begin
    err      = '0;
    count    = '0;
    cap_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      err[i]                = (state_q[i] == FAULT);
      count[i*CW +: CW]     = count_q[i];
      cap_addr[i*AW +: AW]  = cap_q[i];
    end
  end

  assign cfg_err = cfg_err_q;
  assign irq     = irq_q;

`ifdef ADDR_RANGE_MON_ASSERT_EN
  for (genvar g = 0; g < NCH; g++) begin : g_chk
    a_in_range: assert property (@(posedge clk) disable iff (!rst_n) !viol[g])
      else $error("Address is out of range");
  end
`else
  // No checkers in the default build; port behaviour is unchanged.
`endif

endmodule

// File: tb/tb_addr_range_monitor.sv
// tb/tb_addr_range_monitor.sv - directed scoreboard bench for addr_range_monitor
module tb_addr_range_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic [3:0]  valid, clr, err, cfg_err;
  logic [31:0] addr, lo, hi, count, cap_addr;
  logic        irq;

  logic [3:0]  valid2, clr2, err2, cfg_err2;
  logic [31:0] addr2, lo2, hi2, cap2;
  logic [7:0]  count2;
  logic        irq2;

  addr_range_monitor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .valid(valid), .addr(addr), .lo(lo), .hi(hi),
    .clr(clr), .err(err), .count(count), .cap_addr(cap_addr), .cfg_err(cfg_err), .irq(irq)
  );

  addr_range_monitor #(.AW(8), .NCH(4), .CW(2), .THRESH(3)) dut_cw2 (
    .clk(clk), .rst_n(rst_n), .en(en), .valid(valid2), .addr(addr2), .lo(lo2), .hi(hi2),
    .clr(clr2), .err(err2), .count(count2), .cap_addr(cap2), .cfg_err(cfg_err2), .irq(irq2)
  );

  typedef struct {
    int         inst;
    int         ch;
    bit         is_irq;
    logic       e;
    logic [7:0] c;
    logic [7:0] cap;
    logic       cfg;
    logic       irq;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    cw2_exp[5] = '{1, 2, 3, 3, 3};

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_pending();
    exp_t  e;
    string t;
    logic  obs_irq;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.is_irq) begin
        obs_irq = (e.inst == 0) ? irq : irq2;
        cmp({t, ".irq"}, 8'(obs_irq), 8'(e.irq));
      end else if (e.inst == 0) begin
        cmp({t, ".err"},   8'(err[e.ch]), 8'(e.e));
        cmp({t, ".count"}, count[e.ch*8 +: 8], e.c);
        cmp({t, ".cap"},   cap_addr[e.ch*8 +: 8], e.cap);
        cmp({t, ".cfg"},   8'(cfg_err[e.ch]), 8'(e.cfg));
      end else begin
        cmp({t, ".err"},   8'(err2[e.ch]), 8'(e.e));
        cmp({t, ".count"}, {6'd0, count2[e.ch*2 +: 2]}, e.c);
        cmp({t, ".cap"},   cap2[e.ch*8 +: 8], e.cap);
      end
    end
  endtask

  task automatic exp_ch(input string t, input int ch, input logic ev, input logic [7:0] c,
                        input logic [7:0] cap, input logic cfg);
    exp_t e;
    e.inst = 0; e.ch = ch; e.is_irq = 1'b0; e.e = ev; e.c = c; e.cap = cap; e.cfg = cfg; e.irq = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic exp_ch2(input string t, input int ch, input logic ev, input logic [7:0] c,
                         input logic [7:0] cap);
    exp_t e;
    e.inst = 1; e.ch = ch; e.is_irq = 1'b0; e.e = ev; e.c = c; e.cap = cap; e.cfg = 1'b0; e.irq = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic exp_irq(input string t, input int inst, input logic v);
    exp_t e;
    e.inst = inst; e.ch = 0; e.is_irq = 1'b1; e.e = 1'b0; e.c = '0; e.cap = '0; e.cfg = 1'b0; e.irq = v;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic exp_all_zero(input string t);
    for (int ch = 0; ch < 4; ch++) exp_ch(t, ch, 1'b0, 8'h00, 8'h00, 1'b0);
    exp_irq(t, 0, 1'b0);
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [7:0] a);
    valid[ch]        = v;
    addr[ch*8 +: 8]  = a;
  endtask

  task automatic set_bnd(input int ch, input logic [7:0] l, input logic [7:0] h);
    lo[ch*8 +: 8] = l;
    hi[ch*8 +: 8] = h;
  endtask

  task automatic tick();
    @(negedge clk);
    check_pending();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; valid = '0; clr = '0; addr = '0; lo = '0; hi = 32'hFFFF_FFFF;
    valid2 = '0; clr2 = '0; addr2 = '0; lo2 = '0; hi2 = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    exp_all_zero("reset");
    check_pending();
    rst_n = 1'b1;

    // Inclusive bounds, first violation capture, en gating, clear regardless of en.
    set_bnd(0, 8'h10, 8'h20);
    set_ch(0, 1'b1, 8'h10); exp_ch("lo_edge", 0, 1'b0, 8'd0, 8'h00, 1'b0); tick();
    set_ch(0, 1'b1, 8'h20); exp_ch("hi_edge", 0, 1'b0, 8'd0, 8'h00, 1'b0); tick();
    set_ch(0, 1'b1, 8'h21); exp_ch("above_hi", 0, 1'b1, 8'd1, 8'h21, 1'b0); tick();
    set_ch(0, 1'b1, 8'h05); exp_ch("second_viol", 0, 1'b1, 8'd2, 8'h21, 1'b0); tick();
    en = 1'b0;
    set_ch(0, 1'b1, 8'h00); exp_ch("en_off_hold", 0, 1'b1, 8'd2, 8'h21, 1'b0); tick();
    clr[0] = 1'b1; valid[0] = 1'b0;
    exp_ch("clr_en_off", 0, 1'b0, 8'd0, 8'h00, 1'b0); tick();
    clr[0] = 1'b0; en = 1'b1;

    // Inverted bounds suppress violations and raise cfg_err.
    set_bnd(0, 8'h30, 8'h20); set_ch(0, 1'b1, 8'h00);
    exp_ch("bad_cfg", 0, 1'b0, 8'd0, 8'h00, 1'b1); tick();
    set_bnd(0, 8'h10, 8'h20); set_ch(0, 1'b0, 8'h00);
    exp_ch("cfg_ok", 0, 1'b0, 8'd0, 8'h00, 1'b0); tick();

    // Threshold irq: latency two from the fourth violation, drops two cycles after clear.
    set_bnd(2, 8'h40, 8'h80);
    for (int k = 1; k <= 4; k++) begin
      set_ch(2, 1'b1, 8'h01);
      exp_ch("ch2_viol", 2, 1'b1, 8'(k), 8'h01, 1'b0);
      if (k == 4) exp_irq("irq_lat1", 0, 1'b0);
      tick();
    end
    set_ch(2, 1'b0, 8'h00); exp_irq("irq_lat2", 0, 1'b1); tick();
    clr[2] = 1'b1;
    exp_ch("ch2_clr", 2, 1'b0, 8'd0, 8'h00, 1'b0); exp_irq("irq_hold", 0, 1'b1); tick();
    clr[2] = 1'b0;
    exp_irq("irq_drop", 0, 1'b0); tick();

    // Clear coinciding with a violation restarts the record at count 1.
    set_bnd(3, 8'h00, 8'h80);
    for (int k = 1; k <= 7; k++) begin
      set_ch(3, 1'b1, 8'h90);
      exp_ch("ch3_viol", 3, 1'b1, 8'(k), 8'h90, 1'b0);
      tick();
    end
    clr[3] = 1'b1; set_ch(3, 1'b1, 8'hFF);
    exp_ch("clr_and_viol", 3, 1'b1, 8'd1, 8'hFF, 1'b0); tick();
    clr[3] = 1'b0; set_ch(3, 1'b0, 8'h00);
    exp_irq("irq_drop3", 0, 1'b0); tick();

    // All channels clear together, then violate together.
    clr = 4'hF;
    for (int ch = 0; ch < 4; ch++) exp_ch("clr_all", ch, 1'b0, 8'd0, 8'h00, 1'b0);
    tick();
    clr = 4'h0;
    for (int ch = 0; ch < 4; ch++) begin
      set_bnd(ch, 8'h10, 8'h20);
      set_ch(ch, 1'b1, 8'(ch + 1));
      exp_ch("all_viol", ch, 1'b1, 8'd1, 8'(ch + 1), 1'b0);
    end
    tick();
    valid = '0;

    // Asynchronous reset mid-stream, then a fresh violation counts from one.
    set_ch(0, 1'b1, 8'h30); exp_ch("pre_reset", 0, 1'b1, 8'd2, 8'h01, 1'b0); tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_all_zero("async_rst");
    check_pending();
    repeat (2) @(negedge clk);
    exp_all_zero("rst_held");
    check_pending();
    rst_n = 1'b1;
    valid = 4'b0001;
    set_ch(0, 1'b1, 8'h30); exp_ch("post_rst", 0, 1'b1, 8'd1, 8'h30, 1'b0); tick();
    valid = '0;

    // Narrow counter saturates at 3 and keeps the first captured address.
    lo2[15:8] = 8'h40;
    hi2[15:8] = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      valid2[1]   = 1'b1;
      addr2[15:8] = 8'(5 + k);
      exp_ch2("cw2_sat", 1, 1'b1, 8'(cw2_exp[k]), 8'h05);
      if (k == 4) exp_irq("cw2_irq", 1, 1'b1);
      tick();
    end
    valid2 = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
